// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential restoring divider, one quotient bit per clock, MSB first.
//   Unsigned or two's-complement operands, with divide-by-zero and signed
//   overflow (MIN / -1) flags. Result is packed {quotient, remainder}.
//
// Parameters
//   WIDTH      operand width in bits (4..32)
//   SIGNED_EN  0: signed mode not built, is_signed is ignored
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        launch a division (accepted only while idle)
//   is_signed    1 = two's-complement operands, captured with start
//   dividend     numerator, captured with start
//   divisor      denominator, captured with start
//   busy         high from the cycle after start is accepted until validity
//   validity     one-cycle pulse: result and flags are valid
//   div_by_zero  last operation had divisor == 0
//   overflow     last operation was signed MIN / -1
//   result       {quotient, remainder}, held until the next accepted start
//
// Timing: start sampled at edge 0 -> validity in the cycle after edge
// WIDTH+2 (edge 1 for divide-by-zero). The validity cycle itself ignores
// start, so a continuously held start relaunches after one idle cycle.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               validity,
  output logic               div_by_zero,
  output logic               overflow,
  output logic [2*WIDTH-1:0] result
);

  localparam int              CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      cnt_reg;
  logic [WIDTH:0]     rem_reg;       // partial remainder, WIDTH+1 bits
  logic [WIDTH-1:0]   quo_reg;       // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH:0]     dmag_reg;      // divisor magnitude
  logic [WIDTH-1:0]   dvd_reg;       // raw dividend, returned as remainder on divide-by-zero
  logic               zero_reg;
  logic               ovf_pend_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               valid_reg;
  logic               dz_reg;
  logic               ovf_reg;
  logic [2*WIDTH-1:0] result_reg;

  // ---------------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------------
  logic signed_mode;

  generate
    if (SIGNED_EN) begin : g_signed
      assign signed_mode = is_signed;
    end else begin : g_unsigned
      assign signed_mode = 1'b0;
    end
  endgenerate

  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dsr_mag;
  logic             accept;

  assign dvd_neg = signed_mode & dividend[WIDTH-1];
  assign dsr_neg = signed_mode & divisor[WIDTH-1];
  // Unsigned negation of MIN yields 2^(WIDTH-1) exactly, so the dividend
  // magnitude always fits in WIDTH unsigned bits.
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dsr_mag = {1'b0, (dsr_neg ? -divisor : divisor)};

  // The validity cycle blocks acceptance so start coincident with the
  // result pulse is dropped.
  assign accept = (state_reg == IDLE) && start && !valid_reg;

  // ---------------------------------------------------------------------------
  // Restoring step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             diff_neg;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             rem_msb_unused;

  assign shifted  = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
  assign diff     = {1'b0, shifted} - {1'b0, dmag_reg};
  assign diff_neg = diff[WIDTH+1];
  assign quo_fix  = neg_q_reg ? -quo_reg : quo_reg;
  assign rem_fix  = neg_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
  // The remainder stays below the divisor magnitude, so its top bit is
  // always clear after a step.
  assign rem_msb_unused = rem_reg[WIDTH];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (divisor == '0) ? DONE : ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (cnt_reg == LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dmag_reg     <= '0;
      dvd_reg      <= '0;
      zero_reg     <= 1'b0;
      ovf_pend_reg <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      dz_reg       <= 1'b0;
      ovf_reg      <= 1'b0;
      result_reg   <= '0;
    end else begin
      valid_reg <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            dz_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
            dvd_reg      <= dividend;
            zero_reg     <= (divisor == '0);
            ovf_pend_reg <= signed_mode && (dividend == MIN_VAL) && (divisor == '1);
            neg_q_reg    <= dvd_neg ^ dsr_neg;
            neg_r_reg    <= dvd_neg;
            rem_reg      <= '0;
            quo_reg      <= dvd_mag;
            dmag_reg     <= dsr_mag;
            cnt_reg      <= '0;
          end
        end
        ITER: begin
          rem_reg <= diff_neg ? shifted : diff[WIDTH:0];
          quo_reg <= {quo_reg[WIDTH-2:0], ~diff_neg};
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          quo_reg <= quo_fix;
          rem_reg <= {1'b0, rem_fix};
        end
        DONE: begin
          // Result and flags change together with the validity pulse.
          if (zero_reg) begin
            result_reg <= {{WIDTH{1'b1}}, dvd_reg};
            dz_reg     <= 1'b1;
            ovf_reg    <= 1'b0;
          end else begin
            result_reg <= {quo_reg, rem_reg[WIDTH-1:0]};
            dz_reg     <= 1'b0;
            ovf_reg    <= ovf_pend_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign validity    = valid_reg;
  assign div_by_zero = dz_reg;
  assign overflow    = ovf_reg;
  assign result      = result_reg;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider: a 16-bit signed instance and an
//   8-bit unsigned-only instance share the clock and reset. Expected results
//   are queued when an operation is launched and popped when validity pulses.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  flags;   // {div_by_zero, overflow}
    int          lat;
  } exp16_t;

  logic        clk;
  logic        rst_n;

  logic        start16, sgn16;
  logic [15:0] a16, b16;
  logic        busy16, valid16, dz16, ovf16;
  logic [31:0] res16;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, valid8, dz8, ovf8;
  logic [15:0] res8;

  int tests_run    = 0;
  int tests_failed = 0;

  exp16_t      sb16[$];
  logic [15:0] sb8[$];

  seq_divider #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16),
    .dividend(a16), .divisor(b16), .busy(busy16), .validity(valid16),
    .div_by_zero(dz16), .overflow(ovf16), .result(res16)
  );

  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
    .dividend(a8), .divisor(b8), .busy(busy8), .validity(valid8),
    .div_by_zero(dz8), .overflow(ovf8), .result(res8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference quotient/remainder using the simulator's own arithmetic.
  function automatic logic [31:0] model16(bit s, logic [15:0] a, logic [15:0] b);
    longint sa, sd, q, r;
    logic [15:0] uq, ur;
    if (b == 16'h0) return {16'hFFFF, a};
    if (s) begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      q  = sa / sd;
      r  = sa % sd;
      return {q[15:0], r[15:0]};
    end
    uq = a / b;
    ur = a % b;
    return {uq, ur};
  endfunction

  function automatic exp16_t mk16(logic [31:0] res, bit dz, bit ovf, int lat);
    exp16_t e;
    e.res   = res;
    e.flags = {dz, ovf};
    e.lat   = lat;
    return e;
  endfunction

  // Drive one start pulse, queue its expectation, scramble the operands
  // after the capture edge. Returns at the negedge after the start edge.
  task automatic issue16(bit s, logic [15:0] a, logic [15:0] b, exp16_t e);
    @(negedge clk);
    start16 = 1'b1; sgn16 = s; a16 = a; b16 = b;
    sb16.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0; sgn16 = ~s; a16 = ~a; b16 = ~b;
  endtask

  // Count cycles (from the negedge after the start edge) until validity.
  task automatic wait16(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (valid16 !== 1'b1 && lat < 64) begin
      if (busy16 === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy16, valid16, dz16, ovf16, res16} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset16: got busy=%b valid=%b dz=%b ovf=%b res=%h, want all 0",
               busy16, valid16, dz16, ovf16, res16);
    end
    tests_run++;
    if ({busy8, valid8, dz8, ovf8, res8} !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset8: got busy=%b valid=%b dz=%b ovf=%b res=%h, want all 0",
               busy8, valid8, dz8, ovf8, res8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset: outputs cleared");
  endtask

  task automatic test_unsigned();
    logic [15:0] a, b;
    exp16_t e, got;
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        a = 16'd100; b = 16'd7; e = mk16(32'h000E_0002, 1'b0, 1'b0, 18);
      end else begin
        a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(1, 65535));
        e = mk16(model16(1'b0, a, b), 1'b0, 1'b0, 18);
      end
      issue16(1'b0, a, b, e);
      wait16(lat, bcnt);
      got = sb16.pop_front();
      $display("[TB] unsigned %h / %h -> res=%h dz=%b ovf=%b lat=%0d", a, b, res16, dz16, ovf16, lat);
      tests_run++;
      if (res16 !== got.res) begin
        tests_failed++;
        $display("FAIL unsigned_result: got %h want %h", res16, got.res);
      end
      tests_run++;
      if ({dz16, ovf16} !== got.flags) begin
        tests_failed++;
        $display("FAIL unsigned_flags: got dz,ovf=%b want %b", {dz16, ovf16}, got.flags);
      end
      tests_run++;
      if (lat != got.lat || bcnt != got.lat || busy16 !== 1'b0) begin
        tests_failed++;
        $display("FAIL unsigned_timing: got lat=%0d busy_cycles=%0d busy_at_valid=%b want %0d/%0d/0",
                 lat, bcnt, busy16, got.lat, got.lat);
      end
      // validity must be a single-cycle pulse with the result holding
      @(negedge clk);
      tests_run++;
      if (valid16 !== 1'b0 || res16 !== got.res) begin
        tests_failed++;
        $display("FAIL unsigned_pulse: got valid=%b res=%h want 0/%h", valid16, res16, got.res);
      end
    end
  endtask

  task automatic test_signed();
    logic [15:0] a, b;
    exp16_t e, got;
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        a = 16'hFF9C; b = 16'd7;    e = mk16(32'hFFF2_FFFE, 1'b0, 1'b0, 18);
      end else if (i == 1) begin
        a = 16'd100;  b = 16'hFFF9; e = mk16(32'hFFF2_0002, 1'b0, 1'b0, 18);
      end else begin
        a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(1, 65535));
        e = mk16(model16(1'b1, a, b), 1'b0, (a == 16'h8000 && b == 16'hFFFF), 18);
      end
      issue16(1'b1, a, b, e);
      wait16(lat, bcnt);
      got = sb16.pop_front();
      $display("[TB] signed %h / %h -> res=%h dz=%b ovf=%b lat=%0d", a, b, res16, dz16, ovf16, lat);
      tests_run++;
      if (res16 !== got.res) begin
        tests_failed++;
        $display("FAIL signed_result: got %h want %h", res16, got.res);
      end
      tests_run++;
      if ({dz16, ovf16} !== got.flags) begin
        tests_failed++;
        $display("FAIL signed_flags: got dz,ovf=%b want %b", {dz16, ovf16}, got.flags);
      end
      tests_run++;
      if (lat != got.lat || bcnt != got.lat || busy16 !== 1'b0) begin
        tests_failed++;
        $display("FAIL signed_timing: got lat=%0d busy_cycles=%0d busy_at_valid=%b want %0d/%0d/0",
                 lat, bcnt, busy16, got.lat, got.lat);
      end
    end
  endtask

  task automatic test_div_by_zero();
    exp16_t got;
    int lat, bcnt;
    for (int i = 0; i < 2; i++) begin
      issue16(i[0], 16'h1234, 16'h0000, mk16(32'hFFFF_1234, 1'b1, 1'b0, 1));
      wait16(lat, bcnt);
      got = sb16.pop_front();
      $display("[TB] div0 signed=%0d 1234 / 0000 -> res=%h dz=%b ovf=%b lat=%0d", i, res16, dz16, ovf16, lat);
      tests_run++;
      if (res16 !== got.res) begin
        tests_failed++;
        $display("FAIL div0_result: got %h want %h", res16, got.res);
      end
      tests_run++;
      if ({dz16, ovf16} !== got.flags) begin
        tests_failed++;
        $display("FAIL div0_flags: got dz,ovf=%b want %b", {dz16, ovf16}, got.flags);
      end
      tests_run++;
      if (lat != got.lat || bcnt != got.lat || busy16 !== 1'b0) begin
        tests_failed++;
        $display("FAIL div0_timing: got lat=%0d busy_cycles=%0d busy_at_valid=%b want %0d/%0d/0",
                 lat, bcnt, busy16, got.lat, got.lat);
      end
    end
  endtask

  task automatic test_overflow();
    exp16_t got;
    int lat, bcnt;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) issue16(1'b1, 16'h8000, 16'hFFFF, mk16(32'h8000_0000, 1'b0, 1'b1, 18));
      else        issue16(1'b0, 16'h8000, 16'hFFFF, mk16(32'h0000_8000, 1'b0, 1'b0, 18));
      wait16(lat, bcnt);
      got = sb16.pop_front();
      $display("[TB] overflow signed=%0d 8000 / FFFF -> res=%h dz=%b ovf=%b lat=%0d",
               1 - i, res16, dz16, ovf16, lat);
      tests_run++;
      if (res16 !== got.res) begin
        tests_failed++;
        $display("FAIL overflow_result: got %h want %h", res16, got.res);
      end
      tests_run++;
      if ({dz16, ovf16} !== got.flags) begin
        tests_failed++;
        $display("FAIL overflow_flags: got dz,ovf=%b want %b", {dz16, ovf16}, got.flags);
      end
      tests_run++;
      if (lat != got.lat || bcnt != got.lat) begin
        tests_failed++;
        $display("FAIL overflow_timing: got lat=%0d busy_cycles=%0d want %0d", lat, bcnt, got.lat);
      end
    end
  endtask

  task automatic test_abort_and_ignore();
    exp16_t got;
    int lat, bcnt, vcnt;
    // Launch 100/7 and reset it at ITER cycle 5; no expectation is queued.
    @(negedge clk);
    start16 = 1'b1; sgn16 = 1'b0; a16 = 16'd100; b16 = 16'd7;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy16, valid16, dz16, ovf16, res16} !== 36'h0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got busy=%b valid=%b dz=%b ovf=%b res=%h, want all 0",
               busy16, valid16, dz16, ovf16, res16);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (valid16 === 1'b1) vcnt++;
    end
    tests_run++;
    if (vcnt != 0) begin
      tests_failed++;
      $display("FAIL abort_no_valid: got %0d validity pulses want 0", vcnt);
    end
    $display("[TB] abort: reset at ITER cycle 5, validity pulses after=%0d", vcnt);

    // 65535 / 1 with a stray start at cycle 3 that must be ignored.
    @(negedge clk);
    start16 = 1'b1; sgn16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0001;
    sb16.push_back(mk16(32'hFFFF_0000, 1'b0, 1'b0, 18));
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    repeat (3) @(negedge clk);
    start16 = 1'b1; a16 = 16'd5; b16 = 16'd5;
    @(negedge clk);
    start16 = 1'b0;
    wait16(lat, bcnt);
    lat  = lat + 4;
    bcnt = bcnt + 4;
    got  = sb16.pop_front();
    $display("[TB] ignore: FFFF / 0001 with stray start -> res=%h lat=%0d", res16, lat);
    tests_run++;
    if (res16 !== got.res || {dz16, ovf16} !== got.flags) begin
      tests_failed++;
      $display("FAIL ignore_result: got res=%h dz,ovf=%b want %h/%b", res16, {dz16, ovf16}, got.res, got.flags);
    end
    tests_run++;
    if (lat != got.lat || bcnt != got.lat) begin
      tests_failed++;
      $display("FAIL ignore_timing: got lat=%0d busy_cycles=%0d want %0d", lat, bcnt, got.lat);
    end
    vcnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (valid16 === 1'b1 || busy16 === 1'b1) vcnt++;
    end
    tests_run++;
    if (vcnt != 0 || res16 !== got.res) begin
      tests_failed++;
      $display("FAIL ignore_no_rerun: got %0d active cycles res=%h want 0/%h", vcnt, res16, got.res);
    end
  endtask

  task automatic test_back_to_back();
    exp16_t got;
    int lat, bcnt;
    @(negedge clk);
    start16 = 1'b1; sgn16 = 1'b0; a16 = 16'd1000; b16 = 16'd10;
    sb16.push_back(mk16(32'h0064_0000, 1'b0, 1'b0, 18));
    @(posedge clk);
    @(negedge clk);
    // start stays high; the second operands are captured at relaunch
    sgn16 = 1'b1; a16 = 16'hFC18; b16 = 16'd7;
    sb16.push_back(mk16(32'hFF72_FFFA, 1'b0, 1'b0, 18));
    for (int k = 0; k < 2; k++) begin
      wait16(lat, bcnt);
      got = sb16.pop_front();
      $display("[TB] back_to_back op%0d -> res=%h lat=%0d", k, res16, lat);
      tests_run++;
      if (res16 !== got.res || lat != got.lat || bcnt != got.lat) begin
        tests_failed++;
        $display("FAIL b2b_op%0d: got res=%h lat=%0d busy_cycles=%0d want %h/%0d",
                 k, res16, lat, bcnt, got.res, got.lat);
      end
      if (k == 0) begin
        @(negedge clk);   // single idle cycle: start still high but ignored
        tests_run++;
        if (busy16 !== 1'b0 || valid16 !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_gap: got busy=%b valid=%b want 0/0", busy16, valid16);
        end
        @(negedge clk);   // relaunched on the following edge
        start16 = 1'b0;
        tests_run++;
        if (busy16 !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_relaunch: got busy=%b want 1", busy16);
        end
      end
    end
  endtask

  task automatic test_width8();
    logic [7:0]  a, b, q, r;
    logic [15:0] want;
    int lat;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        a = 8'd200; b = 8'd9;
      end else begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(1, 255));
      end
      q = a / b;
      r = a % b;
      @(negedge clk);
      start8 = 1'b1; sgn8 = (i != 0); a8 = a; b8 = b;
      sb8.push_back({q, r});
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0; a8 = ~a; b8 = ~b;
      lat = 0;
      while (valid8 !== 1'b1 && lat < 64) begin
        @(negedge clk);
        lat++;
      end
      want = sb8.pop_front();
      $display("[TB] width8 signed_req=%0d %0d / %0d -> res=%h lat=%0d", i != 0, a, b, res8, lat);
      tests_run++;
      if (res8 !== want || {dz8, ovf8} !== 2'b00) begin
        tests_failed++;
        $display("FAIL width8_result: got res=%h dz,ovf=%b want %h/00", res8, {dz8, ovf8}, want);
      end
      tests_run++;
      if (lat != 10) begin
        tests_failed++;
        $display("FAIL width8_timing: got lat=%0d want 10", lat);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    start8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_abort_and_ignore();
    test_back_to_back();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
